// File: rtl/icap_reg_reader_if.sv
// Fabric-side request/response bundle for the ICAP register reader.
interface icap_rd_if;
  logic        start;
  logic [5:0]  reg_addr;
  logic        busy;
  logic        done;
  logic [15:0] rd_data;
  logic        err;

  modport master (output start, output reg_addr,
                  input  busy, input done, input rd_data, input err);
  modport slave  (input  start, input reg_addr,
                  output busy, output done, output rd_data, output err);
endinterface

// File: rtl/icap_reg_reader.sv
// Reads one Spartan-6 configuration register through ICAP: sync, read header,
// read window with busy/timeout handling, then desync.
module icap_reg_reader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_icap,
  input  logic        rst_n,
  icap_rd_if.slave    bus,
  output logic        icap_ce,
  output logic        icap_wr,
  output logic [15:0] icap_din,
  input  logic [15:0] icap_dout,
  input  logic        icap_busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 4) ? 2 : $clog2(TIMEOUT + 1);
  localparam int unsigned WORD_W = 16;

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_SYNC1, S_SYNC2, S_NOP_A, S_RDHDR, S_NOP_B, S_NOP_C,
    S_TURN1, S_TURN2, S_RDWAIT, S_TURN3, S_TURN4, S_CMD, S_DESYNC,
    S_NOP_D, S_NOP_E, S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [5:0]          addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   cap_q, cap_d;
  logic                tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                err_q, err_d;
  logic                ce_q, ce_d;
  logic                wr_q, wr_d;
  logic [WORD_W-1:0]   din_q, din_d;
  logic [WORD_W-1:0]   word;

  // ICAP expects each byte bit-reversed on both the I and O buses.
  function automatic logic [WORD_W-1:0] byte_rev(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7-i];
      r[8+i]   = w[15-i];
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = '0;
    cap_d     = cap_q;
    tmo_d     = tmo_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    ce_d      = 1'b0;
    wr_d      = 1'b0;
    word      = 16'hFFFF;

    unique case (state_q)
      S_IDLE: begin
        ce_d = 1'b1;
        wr_d = 1'b1;
        if (bus.start) begin
          state_d = S_START;
          addr_d  = bus.reg_addr;
          tmo_d   = 1'b0;
        end
      end
      S_START:  state_d = S_SYNC1;
      S_SYNC1:  begin word = 16'hAA99; state_d = S_SYNC2; end
      S_SYNC2:  begin word = 16'h5566; state_d = S_NOP_A; end
      S_NOP_A:  begin word = 16'h2000; state_d = S_RDHDR; end
      S_RDHDR:  begin word = 16'h2801 | {5'b0, addr_q, 5'b0}; state_d = S_NOP_B; end
      S_NOP_B:  begin word = 16'h2000; state_d = S_NOP_C; end
      S_NOP_C:  begin word = 16'h2000; state_d = S_TURN1; end
      S_TURN1:  begin ce_d = 1'b1; wr_d = 1'b0; state_d = S_TURN2; end
      S_TURN2:  begin ce_d = 1'b1; wr_d = 1'b1; state_d = S_RDWAIT; end
      S_RDWAIT: begin
        wr_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Data capture takes priority over timeout on the final cycle.
        if (cnt_q >= CNT_W'(2) && !icap_busy) begin
          cap_d   = byte_rev(icap_dout);
          state_d = S_TURN3;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          cap_d   = 16'hFFFF;
          state_d = S_TURN3;
        end
      end
      S_TURN3:  begin ce_d = 1'b1; wr_d = 1'b1; state_d = S_TURN4; end
      S_TURN4:  begin ce_d = 1'b1; wr_d = 1'b0; state_d = S_CMD; end
      S_CMD:    begin word = 16'h30A1; state_d = S_DESYNC; end
      S_DESYNC: begin word = 16'h000D; state_d = S_NOP_D; end
      S_NOP_D:  begin word = 16'h2000; state_d = S_NOP_E; end
      S_NOP_E:  begin word = 16'h2000; state_d = S_FIN; end
      S_FIN:    begin ce_d = 1'b1; wr_d = 1'b1; state_d = S_IDLE; end
      default:  begin ce_d = 1'b1; wr_d = 1'b1; state_d = S_IDLE; end
    endcase

    din_d  = byte_rev(word);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    if (state_d == S_FIN) begin
      rd_data_d = cap_q;
      err_d     = tmo_q;
    end
  end

  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      ce_q      <= 1'b1;
      wr_q      <= 1'b1;
      din_q     <= 16'hFFFF;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      ce_q      <= ce_d;
      wr_q      <= wr_d;
      din_q     <= din_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;
  assign bus.err     = err_q;
  assign icap_ce     = ce_q;
  assign icap_wr     = wr_q;
  assign icap_din    = din_q;

endmodule
